// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: word/round/index widths, rotate and P1 helpers,
// and the message-expansion state encoding.
package sm3_pkg;

    localparam int unsigned SM3_WORD_W = 32;
    localparam int unsigned SM3_ROUNDS = 64;
    localparam int unsigned SM3_IDX_W  = 7;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic [SM3_WORD_W-1:0] rotl(input logic [SM3_WORD_W-1:0] x,
                                                   input int unsigned n);
        return (x << n) | (x >> (SM3_WORD_W - n));
    endfunction

    function automatic logic [SM3_WORD_W-1:0] p1(input logic [SM3_WORD_W-1:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    function automatic logic [SM3_WORD_W-1:0] bswap32(input logic [SM3_WORD_W-1:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sm3_msg_expand_if.sv
// Block-in / round-word-out handshake bundle for sm3_msg_expand.
// master = the expander, slave = the upstream/consumer environment.
interface sm3_msg_expand_if;
    import sm3_pkg::*;

    logic [16*SM3_WORD_W-1:0] blk_data;
    logic                     blk_valid;
    logic                     blk_ready;
    logic [SM3_WORD_W-1:0]    w_j;
    logic [SM3_WORD_W-1:0]    wp_j;
    logic [SM3_IDX_W-1:0]     j;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  blk_data, blk_valid, out_ready,
        output blk_ready, w_j, wp_j, j, out_last, out_valid
    );

    modport slave (
        output blk_data, blk_valid, out_ready,
        input  blk_ready, w_j, wp_j, j, out_last, out_valid
    );

endinterface

// File: rtl/sm3_p1.sv
// SM3 P1 permutation, 32-bit, purely combinational.
module sm3_p1
    import sm3_pkg::*;
(
    input  logic [SM3_WORD_W-1:0] x,
    output logic [SM3_WORD_W-1:0] y
);

    assign y = p1(x);

endmodule

// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: loads one 512-bit block, streams W_j / W'_j for j = 0..63.
// Define SM3_MSG_EXPAND_BSWAP_EN to byte-reverse each input word on load.
module sm3_msg_expand
    import sm3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    sm3_msg_expand_if.master bus
);

    localparam logic [SM3_IDX_W-1:0] LAST_IDX = SM3_IDX_W'(SM3_ROUNDS - 1);

    state_t                 state, state_n;
    logic                   load, shift;
    logic [SM3_IDX_W-1:0]   idx;
    logic [SM3_WORD_W-1:0]  win [16];
    logic [SM3_WORD_W-1:0]  p1_in, p1_out, w_new;

    function automatic logic [SM3_WORD_W-1:0] load_word(input logic [SM3_WORD_W-1:0] x);
`ifdef SM3_MSG_EXPAND_BSWAP_EN
        return bswap32(x);
`else
        return x;
`endif
    endfunction

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE: if (bus.blk_valid) begin
                load    = 1'b1;
                state_n = RUN;
            end
            RUN: if (bus.out_ready) begin
                shift = 1'b1;
                if (idx == LAST_IDX) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (clr) begin
            state_n = IDLE;
            load    = 1'b0;
            shift   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // W_(j+16) from the window where win[0] = W_j
    assign p1_in = win[0] ^ win[7] ^ rotl(win[13], 15);

    sm3_p1 u_p1 (
        .x (p1_in),
        .y (p1_out)
    );

    assign w_new = p1_out ^ rotl(win[3], 7) ^ win[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            for (int unsigned k = 0; k < 16; k++) win[k] <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (load) begin
            idx <= '0;
            for (int unsigned k = 0; k < 16; k++)
                win[k] <= load_word(bus.blk_data[16*SM3_WORD_W-1-SM3_WORD_W*k -: SM3_WORD_W]);
        end else if (shift) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + SM3_IDX_W'(1);
            for (int unsigned k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= w_new;
        end
    end

    assign bus.blk_ready = (state == IDLE);
    assign bus.out_valid = (state == RUN);
    assign bus.w_j       = win[0];
    assign bus.wp_j      = win[0] ^ win[4];
    assign bus.j         = idx;
    assign bus.out_last  = (state == RUN) && (idx == LAST_IDX);

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Scoreboard bench for sm3_msg_expand: reference expansion per block, queued
// expectations popped on each output handshake.
module tb_sm3_msg_expand;

    typedef struct {
        logic [31:0] w;
        logic [31:0] wp;
        logic [6:0]  j;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int   cyc = 0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic mon_en   = 1'b0;
    logic abc_mode = 1'b0;
    logic bp_en    = 1'b0;
    int   hs_cnt   = 0;

    logic        stalled = 1'b0;
    logic [31:0] hold_w, hold_wp;
    logic [6:0]  hold_j;
    logic        hold_last;
    exp_t        e;

    logic [511:0] abc_blk;

    sm3_msg_expand_if bus ();

    sm3_msg_expand dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [511:0] to_bus(input logic [511:0] blk);
        logic [511:0] r;
        r = blk;
`ifdef SM3_MSG_EXPAND_BSWAP_EN
        for (int i = 0; i < 16; i++)
            r[511-32*i -: 32] = {blk[511-32*i-24 -: 8], blk[511-32*i-16 -: 8],
                                 blk[511-32*i-8 -: 8],  blk[511-32*i -: 8]};
`endif
        return r;
    endfunction

    task automatic model(input logic [511:0] blk);
        logic [31:0] w [68];
        logic [31:0] t;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 68; i++) begin
            t    = w[i-16] ^ w[i-9] ^ rl(w[i-3], 15);
            w[i] = t ^ rl(t, 15) ^ rl(t, 23) ^ rl(w[i-13], 7) ^ w[i-6];
        end
        for (int i = 0; i < 64; i++)
            sb.push_back('{w: w[i], wp: w[i] ^ w[i+4], j: 7'(i), last: (i == 63)});
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_w", bus.w_j, hold_w);
                chk("stall_wp", bus.wp_j, hold_wp);
                chk("stall_j", 32'(bus.j), 32'(hold_j));
                chk("stall_last", 32'(bus.out_last), 32'(hold_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    chk("extra_word", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("w_j", bus.w_j, e.w);
                    chk("wp_j", bus.wp_j, e.wp);
                    chk("j", 32'(bus.j), 32'(e.j));
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                    if (abc_mode) begin
                        case (bus.j)
                            7'd0: begin
                                chk("abc_w0", bus.w_j, 32'h61626380);
                                chk("abc_wp0", bus.wp_j, 32'h61626380);
                            end
                            7'd12: chk("abc_wp12", bus.wp_j, 32'h9092e200);
                            7'd15: chk("abc_wp15", bus.wp_j, 32'h719c70f5);
                            7'd16: chk("abc_w16", bus.w_j, 32'h9092e200);
                            7'd18: chk("abc_w18", bus.w_j, 32'h000c0606);
                            default: ;
                        endcase
                    end
                end
            end
            stalled   = bus.out_valid && !bus.out_ready;
            hold_w    = bus.w_j;
            hold_wp   = bus.wp_j;
            hold_j    = bus.j;
            hold_last = bus.out_last;
        end
    end

    task automatic send_block(input logic [511:0] blk, input logic keep,
                              output int acc, output int waits);
        bus.blk_data  = to_bus(blk);
        bus.blk_valid = 1'b1;
        acc   = -1;
        waits = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.blk_ready) begin
                model(blk);
                @(posedge clk);
                acc = cyc;
                #1;
                if (!keep) bus.blk_valid = 1'b0;
                break;
            end
            waits++;
        end
        if (acc < 0) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.blk_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int limit);
        for (int n = 0; n < limit; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int acc_a, acc_b, w_a, w_b, cnt;

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        bus.blk_data  = '0;
        bus.blk_valid = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.blk_ready), 32'd1);
        chk("rst_j", 32'(bus.j), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_w", bus.w_j, 32'd0);
        chk("rst_wp", bus.wp_j, 32'd0);

        // abc block, no backpressure, with first-output latency
        @(posedge clk); #1;
        mon_en = 1'b1; abc_mode = 1'b1;
        send_block(abc_blk, 1'b0, acc_a, w_a);
        @(negedge clk);
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_j", 32'(bus.j), 32'd0);
        wait_drain(200);
        @(negedge clk);
        chk("end_valid", 32'(bus.out_valid), 32'd0);
        chk("end_ready", 32'(bus.blk_ready), 32'd1);

        // random backpressure on abc
        @(posedge clk); #1;
        hs_cnt = 0;
        bp_en  = 1'b1;
        send_block(abc_blk, 1'b0, acc_a, w_a);
        wait_drain(3000);
        bp_en = 1'b0;
        chk("hs_count", 32'(hs_cnt), 32'd64);
        abc_mode = 1'b0;

        // back-to-back blocks with blk_valid held
        @(posedge clk); #1;
        send_block(rand_blk(), 1'b1, acc_a, w_a);
        send_block(rand_blk(), 1'b0, acc_b, w_b);
        chk("b2b_ready_low", 32'(w_b), 32'd64);
        chk("b2b_spacing", 32'(acc_b - acc_a), 32'd65);
        wait_drain(200);

        // clr at j = 30
        @(posedge clk); #1;
        abc_mode = 1'b1;
        send_block(abc_blk, 1'b0, acc_a, w_a);
        for (int n = 0; n < 200; n++) begin
            if (bus.j == 7'd30) break;
            @(posedge clk); #1;
        end
        chk("clr_reach", 32'(bus.j), 32'd30);
        mon_en = 1'b0;
        clr    = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_ready", 32'(bus.blk_ready), 32'd1);
        chk("clr_j", 32'(bus.j), 32'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        send_block(abc_blk, 1'b0, acc_a, w_a);
        wait_drain(200);
        abc_mode = 1'b0;

        // async reset mid-cycle at j = 40
        @(posedge clk); #1;
        send_block(rand_blk(), 1'b0, acc_a, w_a);
        for (int n = 0; n < 200; n++) begin
            if (bus.j == 7'd40) break;
            @(posedge clk); #1;
        end
        chk("rst_reach", 32'(bus.j), 32'd40);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ready", 32'(bus.blk_ready), 32'd1);
        chk("arst_j", 32'(bus.j), 32'd0);
        chk("arst_last", 32'(bus.out_last), 32'd0);
        chk("arst_w", bus.w_j, 32'd0);
        chk("arst_wp", bus.wp_j, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        chk("no_resume", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm3_msg_expand.md
# sm3_msg_expand

SM3 message-expansion engine: accepts one padded 512-bit message block and streams the expanded words W_j and W'_j (j = 0..63) one per handshake to the compression round datapath. That datapath applies FF_j/GG_j and consumes the stream in order. This block is the producer side of the round-word interface. The j index it emits is the same 7-bit round index the boolean-function logic selects on.

## Interface
Parameters
- none; all widths fixed by SM3 (32-bit words, 64 rounds, 7-bit index).

Ports
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort; returns to IDLE, drops current block
- blk_data  input  512  padded block; word 0 = blk_data[511:480], word 15 = blk_data[31:0]
- blk_valid  input  1  blk_data valid
- blk_ready  output  1  block may be accepted
- w_j  output  32  W_j
- wp_j  output  32  W'_j = W_j ^ W_(j+4)
- j  output  7  round index 0..63 of current output
- out_last  output  1  high with j == 63
- out_valid  output  1  w_j/wp_j/j valid
- out_ready  input  1  consumer accepts current word

## Operation
- States: IDLE, RUN. Reset state IDLE.
- Window: 16 x 32-bit registers win[0..15]; win[0] = W_j, so win[4] = W_(j+4).
- IDLE: blk_ready = 1, out_valid = 0. On blk_valid && blk_ready, load win[k] = word k, set j = 0, enter RUN.
- RUN: blk_ready = 0, out_valid = 1, w_j = win[0], wp_j = win[0] ^ win[4].
- On out_valid && out_ready: shift win[k] <= win[k+1] for k = 0..14, and load win[15] <= P1(win[0] ^ win[7] ^ rotl(win[13],15)) ^ rotl(win[3],7) ^ win[10]. This is W_(j+16). Increment j.
- P1(x) = x ^ rotl(x,15) ^ rotl(x,23). All arithmetic is XOR/rotate, 32-bit, no carries.
- On a handshake with j == 63: enter IDLE, j <= 0. W_64..W_67 are computed but never emitted beyond their use in wp_j.
- clr has priority over handshakes. In any state: next state IDLE, j <= 0, out_valid drops next cycle. The window contents are don't-care.
- out_valid stalled (out_ready = 0): w_j, wp_j, j, out_last held stable. Window does not shift.
- blk_valid while RUN is ignored; the upstream holds its data until blk_ready returns.

## Timing
- Reset values: out_valid 0, blk_ready 1, j 0, out_last 0, w_j 0, wp_j 0. The window is cleared to 0.
- rst mid-block: immediate abort, outputs to reset values asynchronously, and no partial stream resumes.
- Latency: block accepted at edge k gives out_valid = 1 and j = 0 from edge k (visible the cycle after acceptance).
- Throughput: with out_ready held high, 64 output cycles plus 1 IDLE cycle, i.e. 65 cycles per block.
- blk_ready is decoded from the state register only. There is no combinational path from out_ready to blk_ready.
- w_j and wp_j are driven from registers. The next-word logic has exactly one P1 stage between registers.

## Configuration
- SM3_MSG_EXPAND_BSWAP_EN defined: each 32-bit word of blk_data is byte-reversed on load. This is for little-endian upstream buses.
- Not defined: words are loaded as-is (big-endian, SM3 native). No other behaviour changes.

## Structure
- Shared package sm3_pkg:
  - SM3_WORD_W = 32, SM3_ROUNDS = 64, SM3_IDX_W = 7
  - rotl and P1 functions
  - state enum {IDLE, RUN}
- One sub-module, sm3_p1: 32-bit combinational P1 permutation, reused by the compression datapath's P0/P1 logic.

## Test plan
- Reset then "abc" block (61626380, 00000000 x14, 00000018), out_ready = 1:
  - j = 0 gives w_j 61626380, wp_j 61626380
  - j = 12 gives wp_j 9092e200
  - j = 15 gives wp_j 719c70f5
  - j = 16 gives w_j 9092e200
  - j = 18 gives w_j 000c0606
- Random out_ready backpressure on the "abc" block: the sequence matches the stall-free sequence, outputs are stable while stalled, and exactly 64 handshakes occur with out_last only at j = 63.
- Back-to-back blocks with blk_valid held: blk_ready 0 throughout RUN, and the second block's j = 0 appears 65 cycles after the first acceptance.
- clr pulse at j = 30: out_valid 0 next cycle, blk_ready 1, and the next block restarts at j = 0 with correct words.
- Async rst asserted at j = 40 (mid-cycle): outputs return to reset values without waiting for a clock edge, and the stream does not resume after release.
- With SM3_MSG_EXPAND_BSWAP_EN defined: input word 80636261 yields w_j 61626380 at j = 0.
